// File: rtl/pico_io_pkg.sv
// Shared definitions for the pico_io_ports slice: port width, default
// address bases and the interrupt FSM state encoding.
package pico_io_pkg;

    localparam int PORT_W = 8;

    localparam logic [PORT_W-1:0] DEFAULT_OUT_BASE = 8'h00;
    localparam logic [PORT_W-1:0] DEFAULT_IN_BASE  = 8'h00;

    typedef enum logic [1:0] {
        IRQ_IDLE     = 2'd0,
        IRQ_REQ      = 2'd1,
        IRQ_SERVICED = 2'd2
    } irq_state_e;

endpackage

// File: rtl/pico_io_sync.sv
// One 8-bit input synchroniser with a history flop and a change flag.
// The flag is held off until the chain and history hold real samples.
module pico_io_sync
    import pico_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [PORT_W-1:0] async_i,
    output logic [PORT_W-1:0] sync_o,
    output logic              changed_o
);

    logic [PORT_W-1:0]  chain_q [SYNC_STAGES];
    logic [PORT_W-1:0]  hist_q;
    logic [SYNC_STAGES:0] prime_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < SYNC_STAGES; k++) chain_q[k] <= '0;
            hist_q  <= '0;
            prime_q <= '0;
        end else begin
            chain_q[0] <= async_i;
            for (int k = 1; k < SYNC_STAGES; k++) chain_q[k] <= chain_q[k-1];
            hist_q  <= chain_q[SYNC_STAGES-1];
            prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Post-reset filling of the chain must not look like an input change.
    assign sync_o    = chain_q[SYNC_STAGES-1];
    assign changed_o = prime_q[SYNC_STAGES] && (sync_o != hist_q);

endmodule

// File: rtl/pico_io_ports.sv
// PicoBlaze-style I/O port block: output registers, synchronised input ports,
// and (with PICO_IO_IRQ_EN defined) change status, mask and interrupt FSM.
module pico_io_ports
    import pico_io_pkg::*;
#(
    parameter int                N_OUT       = 2,
    parameter int                N_IN        = 2,
    parameter logic [PORT_W-1:0] OUT_BASE    = DEFAULT_OUT_BASE,
    parameter logic [PORT_W-1:0] IN_BASE     = DEFAULT_IN_BASE,
    parameter int                SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PORT_W-1:0]        port_id,
    input  logic                     write_strobe,
    input  logic                     read_strobe,
    input  logic [PORT_W-1:0]        out_port,
    output logic [PORT_W-1:0]        in_port,
    input  logic [PORT_W*N_IN-1:0]   ext_in,
    output logic [PORT_W*N_OUT-1:0]  ext_out,
    output logic                     interrupt,
    input  logic                     interrupt_ack,
    output irq_state_e               dbg_irq_state
);

    // Strobes are single-cycle qualifiers sampled on the rising edge together
    // with port_id/out_port; there is no back-pressure, every strobe completes.

    logic [N_IN-1:0][PORT_W-1:0]  sync_val;
    logic [N_IN-1:0]              changed;
    logic [N_OUT-1:0][PORT_W-1:0] out_q, out_d;
    logic [PORT_W-1:0]            in_q, in_d;

    for (genvar g = 0; g < N_IN; g++) begin : g_sync
        pico_io_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk_i     (clk),
            .rst_ni    (reset),
            .async_i   (ext_in[PORT_W*g +: PORT_W]),
            .sync_o    (sync_val[g]),
            .changed_o (changed[g])
        );
    end

`ifdef PICO_IO_IRQ_EN
    localparam logic [PORT_W-1:0] MASK_WR_ADDR = OUT_BASE + PORT_W'(N_OUT);
    localparam logic [PORT_W-1:0] STATUS_ADDR  = IN_BASE + PORT_W'(N_IN);
    localparam logic [PORT_W-1:0] MASK_RD_ADDR = IN_BASE + PORT_W'(N_IN + 1);

    logic [N_IN-1:0] status_q, status_d, mask_q, mask_d;
    logic            status_clr, pending, irq_q;
    irq_state_e      state_q;

    assign status_clr = read_strobe && (port_id == STATUS_ADDR);
    assign pending    = |(status_q & mask_q);

    always_comb begin
        mask_d = mask_q;
        if (write_strobe && (port_id == MASK_WR_ADDR)) mask_d = out_port[N_IN-1:0];
        // A change seen in the clearing cycle survives the clear.
        status_d = (status_q & ~{N_IN{status_clr}}) | changed;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_q <= '0;
            mask_q   <= '0;
        end else begin
            status_q <= status_d;
            mask_q   <= mask_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IRQ_IDLE;
            irq_q   <= 1'b0;
        end else begin
            case (state_q)
                IRQ_IDLE: if (pending) begin
                    state_q <= IRQ_REQ;
                    irq_q   <= 1'b1;
                end
                IRQ_REQ: if (interrupt_ack) begin
                    state_q <= IRQ_SERVICED;
                    irq_q   <= 1'b0;
                end
                IRQ_SERVICED: if (!pending) state_q <= IRQ_IDLE;
                default: begin
                    state_q <= IRQ_IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt     = irq_q;
    assign dbg_irq_state = state_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{read_strobe, interrupt_ack, changed};
    assign interrupt         = 1'b0;
    assign dbg_irq_state     = IRQ_IDLE;
`endif

    always_comb begin
        out_d = out_q;
        if (write_strobe) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (port_id == OUT_BASE + PORT_W'(i)) out_d[i] = out_port;
            end
        end
        in_d = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (port_id == IN_BASE + PORT_W'(i)) in_d = sync_val[i];
        end
`ifdef PICO_IO_IRQ_EN
        if (port_id == STATUS_ADDR)  in_d = PORT_W'(status_q);
        if (port_id == MASK_RD_ADDR) in_d = PORT_W'(mask_q);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
            in_q  <= '0;
        end else begin
            out_q <= out_d;
            in_q  <= in_d;
        end
    end

    assign ext_out = out_q;
    assign in_port = in_q;

endmodule

// File: tb/tb_pico_io_ports.sv
// Self-checking bench for pico_io_ports (default parameters), covering both
// builds of PICO_IO_IRQ_EN.
module tb_pico_io_ports;
    import pico_io_pkg::*;

    localparam int S = 2;
    localparam int W = 25;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  port_id = '0;
    logic        write_strobe = 1'b0;
    logic        read_strobe = 1'b0;
    logic [7:0]  out_port = '0;
    logic [7:0]  in_port;
    logic [15:0] ext_in = '0;
    logic [15:0] ext_out;
    logic        interrupt;
    logic        interrupt_ack = 1'b0;
    irq_state_e  dbg_irq_state;

    int n_cmp = 0;
    int n_fail = 0;

    logic [W-1:0] exp_q[$];
    logic [15:0]  cap[$];
    logic [7:0]   m_out [2];
    logic [1:0]   m_status, m_mask;
    int           m_state, m_edges;

    typedef struct {
        string      name;
        logic [7:0] pid;
        logic       we;
        logic [7:0] data;
        logic [15:0] exp_out;
    } wr_vec_t;
    wr_vec_t wv [5];

    always #5 clk = ~clk;

    pico_io_ports #(
        .N_OUT(2), .N_IN(2), .OUT_BASE(8'h00), .IN_BASE(8'h00), .SYNC_STAGES(S)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .port_id       (port_id),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .out_port      (out_port),
        .in_port       (in_port),
        .ext_in        (ext_in),
        .ext_out       (ext_out),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .dbg_irq_state (dbg_irq_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_out[0] = '0; m_out[1] = '0;
        m_status = '0; m_mask = '0; m_state = 0; m_edges = 0;
        cap.delete();
    endtask

    // Synchronised value visible after edge k: the sample taken S-1 edges earlier.
    function automatic logic [15:0] sync_at(input int k);
        if (k - S < 0) return 16'h0000;
        return cap[k - S];
    endfunction

    // Advance model by one clock edge using the currently driven inputs, then the DUT.
    task automatic tick();
        int n, p;
        logic [15:0] s_now;
        logic [7:0]  nx_in;
`ifdef PICO_IO_IRQ_EN
        logic [15:0] s_prev;
        logic [1:0]  chg, pend;
`endif
        n = m_edges + 1;
        p = int'(port_id);
        s_now = sync_at(n - 1);
        nx_in = 8'h00;
        if (p < 2) nx_in = s_now[8*p +: 8];
`ifdef PICO_IO_IRQ_EN
        s_prev = sync_at(n - 2);
        chg = '0;
        for (int i = 0; i < 2; i++)
            if (n >= S + 2 && s_now[8*i +: 8] != s_prev[8*i +: 8]) chg[i] = 1'b1;
        if (p == 2) nx_in = {6'b0, m_status};
        if (p == 3) nx_in = {6'b0, m_mask};
        pend = m_status & m_mask;
        case (m_state)
            0:       if (pend != 0) m_state = 1;
            1:       if (interrupt_ack) m_state = 2;
            default: if (pend == 0) m_state = 0;
        endcase
        if (read_strobe && p == 2) m_status = '0;
        m_status = m_status | chg;
        if (write_strobe && p == 2) m_mask = out_port[1:0];
`endif
        if (write_strobe && p < 2) m_out[p] = out_port;
        cap.push_back(ext_in);
        m_edges++;
        exp_q.push_back({(m_state == 1), nx_in, m_out[1], m_out[0]});
        @(posedge clk);
        #1;
    endtask

    task automatic score();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL score: expected queue empty");
            return;
        end
        e = exp_q.pop_front();
        check("sb_ext_out", 32'(ext_out), 32'(e[15:0]));
        check("sb_in_port", 32'(in_port), 32'(e[23:16]));
        check("sb_interrupt", 32'(interrupt), 32'(e[24]));
    endtask

    task automatic wr(input logic [7:0] pid, input logic [7:0] d);
        port_id = pid; out_port = d; write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic rd_strobe(input logic [7:0] pid);
        port_id = pid; read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        wv[0] = '{"wr_p1",        8'd1, 1'b1, 8'hA5, 16'hA500};
        wv[1] = '{"wr_p0",        8'd0, 1'b1, 8'h5A, 16'hA55A};
        wv[2] = '{"wr_unmapped",  8'd5, 1'b1, 8'hFF, 16'hA55A};
        wv[3] = '{"no_strobe",    8'd1, 1'b0, 8'h33, 16'hA55A};
        wv[4] = '{"wr_mask_addr", 8'd2, 1'b1, 8'h00, 16'hA55A};

        model_reset();
        #12;
        check("rst_ext_out", 32'(ext_out), 32'h0);
        check("rst_in_port", 32'(in_port), 32'h0);
        check("rst_interrupt", 32'(interrupt), 32'h0);
        check("rst_state", 32'(dbg_irq_state), 32'(IRQ_IDLE));
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            port_id = wv[i].pid; out_port = wv[i].data; write_strobe = wv[i].we;
            tick();
            write_strobe = 1'b0;
            check(wv[i].name, 32'(ext_out), 32'(wv[i].exp_out));
        end

        // Input port read latency through the synchroniser.
        ext_in = 16'h3C00; port_id = 8'd1;
        for (int k = 0; k < S + 2; k++) begin
            tick();
            if (in_port == 8'h3C) break;
        end
        check("rd_p1", 32'(in_port), 32'h3C);
        port_id = 8'd0; tick();
        check("rd_p0", 32'(in_port), 32'h00);
        port_id = 8'd4; tick();
        check("rd_unmapped", 32'(in_port), 32'h00);

`ifdef PICO_IO_IRQ_EN
        wr(8'd2, 8'h01);
        rd_strobe(8'd2);
        port_id = 8'd4; tick();
        check("idle_start", 32'(dbg_irq_state), 32'(IRQ_IDLE));
        ext_in = ext_in ^ 16'h0001;
        for (int k = 0; k < S + 1; k++) tick();
        check("irq_early", 32'(interrupt), 32'h0);
        tick();
        check("irq_raise", 32'(interrupt), 32'h1);
        interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
        check("irq_ack", 32'(interrupt), 32'h0);
        check("serviced", 32'(dbg_irq_state), 32'(IRQ_SERVICED));
        rd_strobe(8'd2);
        check("status_rd1", 32'(in_port), 32'h01);
        tick();
        check("status_rd2", 32'(in_port), 32'h00);
        check("idle_after", 32'(dbg_irq_state), 32'(IRQ_IDLE));
        interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
        check("ack_idle_ignored", 32'(dbg_irq_state), 32'(IRQ_IDLE));

        // Clearing the mask while requesting must not drop the request.
        ext_in = ext_in ^ 16'h0001;
        for (int k = 0; k < S + 2; k++) tick();
        check("irq_again", 32'(interrupt), 32'h1);
        wr(8'd2, 8'h00);
        check("mask_clr_keeps", 32'(interrupt), 32'h1);
        tick();
        check("mask_clr_keeps2", 32'(interrupt), 32'h1);
        interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
        check("ack_after_clr", 32'(interrupt), 32'h0);
        rd_strobe(8'd2);
        port_id = 8'd4; tick();
        check("idle_after_clr", 32'(dbg_irq_state), 32'(IRQ_IDLE));
        wr(8'd2, 8'h01);

        // Change detected in the same cycle as the clearing read.
        ext_in = ext_in ^ 16'h0001;
        port_id = 8'd4; tick(); tick();
        rd_strobe(8'd2);
        tick();
        check("clr_race", 32'(in_port & 8'h01), 32'h1);
        check("irq_before_rst", 32'(interrupt), 32'h1);
`else
        wr(8'd2, 8'hFF);
        for (int t = 0; t < 4; t++) begin
            ext_in = ext_in ^ 16'h0101;
            for (int k = 0; k < S + 2; k++) tick();
            check("noirq_interrupt", 32'(interrupt), 32'h0);
        end
        port_id = 8'd2; tick();
        check("noirq_status_rd", 32'(in_port), 32'h00);
        port_id = 8'd3; tick();
        check("noirq_mask_rd", 32'(in_port), 32'h00);
        check("noirq_ext_out", 32'(ext_out), 32'hA55A);
`endif

        // Asynchronous reset in mid-cycle.
        #2;
        reset = 1'b0;
        #1;
        check("arst_interrupt", 32'(interrupt), 32'h0);
        check("arst_ext_out", 32'(ext_out), 32'h0);
        check("arst_in_port", 32'(in_port), 32'h0);
        check("arst_state", 32'(dbg_irq_state), 32'(IRQ_IDLE));
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        ext_in = ext_in | 16'h0101;
        wr(8'd2, 8'h01);
        port_id = 8'd4;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("no_spurious_irq", 32'(interrupt), 32'h0);
        end
        port_id = 8'd2; tick();
        check("post_rst_status", 32'(in_port), 32'h00);
        port_id = 8'd3; tick();
`ifdef PICO_IO_IRQ_EN
        check("post_rst_mask", 32'(in_port), 32'h01);
`else
        check("post_rst_mask", 32'(in_port), 32'h00);
`endif

        // Randomised traffic against the reference model.
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            port_id       = 8'($urandom_range(0, 5));
            write_strobe  = ($urandom_range(0, 3) == 0);
            read_strobe   = ($urandom_range(0, 3) == 0);
            out_port      = 8'($urandom);
            interrupt_ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) ext_in = ext_in ^ (16'h1 << $urandom_range(0, 15));
            tick();
            score();
        end
        write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pico_io_ports.md
PICO_IO_PORTS -- requirements
Module: pico_io_ports

Interface
REQ-001 Parameter: N_OUT, default 2, number of 8-bit output ports, range 1..8.
REQ-002 Parameter: N_IN, default 2, number of 8-bit input ports, range 1..8.
REQ-003 Parameter: OUT_BASE, default 8'h00, port_id of output port 0.
REQ-004 Parameter: IN_BASE, default 8'h00, port_id of input port 0.
REQ-005 Parameter: SYNC_STAGES, default 2, synchroniser depth on ext_in, range 2..3.
REQ-006 Port: clk  in  1  single system clock; all flops rising-edge.
REQ-007 Port: reset  in  1  asynchronous, active-low reset.
REQ-008 Port: port_id  in  8  processor port address.
REQ-009 Port: write_strobe  in  1  processor output strobe, one cycle.
REQ-010 Port: read_strobe  in  1  processor input strobe, one cycle.
REQ-011 Port: out_port  in  8  processor write data.
REQ-012 Port: in_port  out  8  processor read data.
REQ-013 Port: ext_in  in  8*N_IN  asynchronous external inputs, port i = bits [8i+7:8i].
REQ-014 Port: ext_out  out  8*N_OUT  registered output ports, port i = bits [8i+7:8i].
REQ-015 Port: interrupt  out  1  interrupt request to processor.
REQ-016 Port: interrupt_ack  in  1  processor interrupt acknowledge, one cycle.

Function
REQ-017 Write: write_strobe high and port_id = OUT_BASE+i (i<N_OUT) SHALL load out_port into output register i at that clock edge; other addresses ignored.
REQ-018 Mask register SHALL be written at OUT_BASE+N_OUT; bit i enables change interrupt for input port i; bits >= N_IN read 0.
REQ-019 ext_in SHALL pass through SYNC_STAGES flops plus one history flop; all decode and reads use synchronised value only.
REQ-020 in_port SHALL be registered: next cycle = sync value of port i when port_id = IN_BASE+i, status register when port_id = IN_BASE+N_IN, mask register when IN_BASE+N_IN+1, else 8'h00; latency 1 cycle.
REQ-021 Status bit i SHALL set when any bit of synchronised port i differs from its history value.
REQ-022 read_strobe with port_id = IN_BASE+N_IN SHALL clear all status bits at that edge; a change detected in the same cycle SHALL win (bit stays 1).
REQ-023 Interrupt FSM states: IDLE, REQ, SERVICED.
REQ-024 IDLE -> REQ when (status & mask) != 0; interrupt = 1 only in REQ.
REQ-025 REQ -> SERVICED on interrupt_ack; interrupt deasserts next cycle.
REQ-026 SERVICED -> IDLE when (status & mask) == 0; a new change while SERVICED keeps FSM in SERVICED (no re-request until cleared and re-set).
REQ-027 Clearing mask while in REQ SHALL not drop interrupt; only interrupt_ack leaves REQ.
REQ-028 interrupt_ack outside REQ SHALL be ignored.

Reset
REQ-029 reset low SHALL asynchronously clear: ext_out, in_port, mask, status, synchroniser and history flops to 0, FSM to IDLE, interrupt to 0.
REQ-030 Reset deassertion mid-operation: no status bit SHALL set on the first SYNC_STAGES+1 cycles after release (history initialised from sync chain).

Configuration
REQ-031 Macro PICO_IO_IRQ_EN defined: REQ-018, REQ-021..REQ-028 implemented.
REQ-032 Macro absent: no status, mask, or FSM logic; interrupt tied 0; reads of IN_BASE+N_IN and IN_BASE+N_IN+1 return 8'h00; write to OUT_BASE+N_OUT ignored.

Structure
REQ-033 Shared package pico_io_pkg SHALL hold port width (8), FSM state encoding, default OUT_BASE/IN_BASE.
REQ-034 Sub-module pico_io_sync SHALL implement one 8-bit synchroniser + history + change flag, instantiated N_IN times.

Verification
REQ-035 N_OUT=2: write 8'hA5 to OUT_BASE+1 -> ext_out[15:8]=8'hA5 next edge, ext_out[7:0] unchanged; write to OUT_BASE+5 -> no change.
REQ-036 ext_in port 1 = 8'h3C, port_id=IN_BASE+1 -> in_port=8'h3C within SYNC_STAGES+2 cycles.
REQ-037 Mask=8'h01, toggle ext_in bit 0 -> interrupt=1 after SYNC_STAGES+2 cycles; ack -> 0 next cycle; status read -> 8'h01 then 8'h00, FSM IDLE.
REQ-038 Change on port 0 in same cycle as status read-strobe -> status bit 0 remains 1.
REQ-039 reset pulsed low while interrupt=1 -> interrupt, ext_out, mask, status all 0 immediately, no spurious interrupt after release.
REQ-040 Build without PICO_IO_IRQ_EN: toggle inputs, mask write 8'hFF -> interrupt stays 0, status address reads 8'h00.
